gray_checker: RTL and testbench
===============================

GRAY_CHECKER -- requirements
Module: gray_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, meaning the Gray code width in bits (legal range 2..8).
REQ-002 The block SHALL have parameter WRAP_W, default 4, meaning the width of the wrap counter.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port Valid, input, 1 bit: GrayIn is sampled on this edge.
REQ-006 The block SHALL have port GrayIn, input, WIDTH bits: the received Gray-coded count value.
REQ-007 The block SHALL have port Binary, output, WIDTH bits, registered: the decoded count of the last accepted sample.
REQ-008 The block SHALL have port Locked, output, 1 bit, registered: high while tracking a legal sequence.
REQ-009 The block SHALL have port StepError, output, 1 bit, registered: one-cycle pulse on an illegal step.
REQ-010 The block SHALL have port Wraps, output, WRAP_W bits, registered: count of max-to-0 wraps, saturating.
REQ-011 The block SHALL have port Overflow, output, 1 bit, registered: sticky, set on the first wrap.

Function
REQ-012 Decode SHALL be b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] XOR g[i], for i descending.
REQ-013 The FSM SHALL have three states: IDLE, TRACK and FAULT.
REQ-014 Samples SHALL be taken only on edges where Valid=1; with Valid=0 all state and outputs SHALL hold, except that StepError SHALL clear.
REQ-015 In IDLE, on Valid: Binary <= decode(GrayIn), store GrayIn as the reference, Locked <= 1, next state TRACK; the first sample SHALL never cause an error.
REQ-016 In TRACK, on Valid with GrayIn equal to the stored reference: this is a repeat, no change and no error.
REQ-017 In TRACK, on Valid with decode(GrayIn) = (Binary + 1) mod 2^WIDTH: Binary and the reference SHALL update.
REQ-018 A legal step from Binary = 2^WIDTH-1 to 0 is a wrap: Wraps <= Wraps+1, saturating at all-ones, and Overflow <= 1.
REQ-019 In TRACK, any other Valid value (backward step, skip, or multi-bit change) is an error:
  - StepError <= 1 for exactly one cycle.
  - Locked <= 0.
  - Binary, the reference and Wraps hold.
  - Next state FAULT.
REQ-020 In FAULT, on the next Valid, the block SHALL re-lock unconditionally: Binary <= decode(GrayIn), the reference updates, Locked <= 1, next state TRACK, and no wrap is counted.
REQ-021 Output latency SHALL be exactly one clock from the sampling edge to the updated outputs; there is no combinational path from inputs to outputs.
REQ-022 Overflow SHALL remain 1 until reset; Wraps SHALL not roll over.

Reset
REQ-023 On a rising edge with Reset=0, the block SHALL set Binary=0, Locked=0, StepError=0, Wraps=0, Overflow=0, the reference to 0, and the state to IDLE.
REQ-024 Reset SHALL dominate Valid on the same edge, including mid-sequence and in FAULT.
REQ-025 After reset deassertion, the first Valid SHALL be handled per REQ-015.

Verification
REQ-026 The bench SHALL cover these scenarios (WIDTH=3, WRAP_W=4):
  - Full sequence: Reset pulse, then Valid every cycle with 000,001,011,010,110,111,101,100,000. Required: Binary 0,1,2,3,4,5,6,7,0, each one cycle after its sample; Locked=1 from the first sample; Wraps=1 and Overflow=1 after the final 000; StepError never asserted.
  - Repeat: lock on 011, then 011 again. Required: Binary stays 2, StepError=0, Locked=1.
  - Skip: lock on 001, then 010. Required: StepError=1 for one cycle, Locked=0, Binary stays 1. Then 110. Required: Binary=4, Locked=1, no error.
  - Backward step: lock on 011, then 001. Required: StepError pulse and state FAULT.
  - Saturation and gaps: 17 full wraps with Valid idle gaps of 0-3 cycles. Required: Wraps=15 and Overflow=1; outputs unchanged during gaps.
  - Mid-stream reset: Reset=0 while Valid=1 and GrayIn=110. Required: all outputs 0 on the next edge; the first post-reset sample 101 gives Binary=6 with no error.

Source files
------------

// File: rtl/gray_checker.sv
// rtl/gray_checker.sv - Gray-coded counter sequence checker with wrap accounting
//
// Purpose:
//   Samples a Gray-coded count when Valid is high, decodes it to binary and
//   checks that successive samples form a legal +1 sequence. Repeats are
//   accepted silently. Any other change raises a one-cycle StepError, drops
//   Locked and parks in FAULT until the next sample, which re-locks
//   unconditionally. Legal max-to-0 steps are counted in a saturating wrap
//   counter, and a sticky Overflow flag is raised on the first wrap.
//
// Ports:
//   Clk       in   clock, all state changes on the rising edge
//   Reset     in   synchronous reset, active low
//   Valid     in   GrayIn is sampled on edges where this is high
//   GrayIn    in   WIDTH-bit Gray-coded count
//   Binary    out  decoded count of the last accepted sample (registered)
//   Locked    out  high while tracking a legal sequence (registered)
//   StepError out  one-cycle pulse on an illegal step (registered)
//   Wraps     out  saturating count of max-to-0 wraps (registered)
//   Overflow  out  sticky, set on the first wrap (registered)

module gray_checker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [WIDTH-1:0]  GrayIn,
  output logic [WIDTH-1:0]  Binary,
  output logic              Locked,
  output logic              StepError,
  output logic [WRAP_W-1:0] Wraps,
  output logic              Overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  ref_gray;
  logic [WIDTH-1:0]  sample_bin;
  logic [WIDTH-1:0]  next_bin;
  logic              legal_step;
  logic              is_wrap;

  // MSB passes straight through; each lower bit folds in the decoded bit above.
  function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    sample_bin = gray_decode(GrayIn);
    next_bin   = Binary + 1'b1;
    legal_step = (sample_bin == next_bin);
    // next_bin rolls to zero only from the all-ones count
    is_wrap    = &Binary;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      ref_gray  <= '0;
      Binary    <= '0;
      Locked    <= 1'b0;
      StepError <= 1'b0;
      Wraps     <= '0;
      Overflow  <= 1'b0;
    end else begin
      // StepError is a pulse: cleared on every edge unless re-raised below.
      StepError <= 1'b0;
      if (Valid) begin
        case (state)
          IDLE, FAULT: begin
            // First sample after reset or after a fault: adopt it, never flag it.
            Binary   <= sample_bin;
            ref_gray <= GrayIn;
            Locked   <= 1'b1;
            state    <= TRACK;
          end
          TRACK: begin
            if (GrayIn == ref_gray) begin
              // repeat of the current value: nothing to do
            end else if (legal_step) begin
              Binary   <= sample_bin;
              ref_gray <= GrayIn;
              if (is_wrap) begin
                if (!(&Wraps)) begin
                  Wraps <= Wraps + 1'b1;
                end
                Overflow <= 1'b1;
              end
            end else begin
              StepError <= 1'b1;
              Locked    <= 1'b0;
              state     <= FAULT;
            end
          end
          default: begin
            state  <= IDLE;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_checker.sv
// tb/tb_gray_checker.sv - directed table-driven bench for gray_checker

module tb_gray_checker;

  localparam int WIDTH  = 3;
  localparam int WRAP_W = 4;

  logic              Clk;
  logic              Reset;
  logic              Valid;
  logic [WIDTH-1:0]  GrayIn;
  logic [WIDTH-1:0]  Binary;
  logic              Locked;
  logic              StepError;
  logic [WRAP_W-1:0] Wraps;
  logic              Overflow;

  gray_checker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Valid     (Valid),
    .GrayIn    (GrayIn),
    .Binary    (Binary),
    .Locked    (Locked),
    .StepError (StepError),
    .Wraps     (Wraps),
    .Overflow  (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       valid;
    logic [2:0] gray;
    logic [2:0] bin;
    logic       locked;
    logic       step_err;
    logic [3:0] wraps;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   nchecks = 0;
  int   nerrors = 0;

  function automatic vec_t mk(string n, logic r, logic v, logic [2:0] g, logic [2:0] b,
                              logic l, logic se, logic [3:0] w, logic o);
    vec_t x;
    x.name = n; x.rst_n = r; x.valid = v; x.gray = g; x.bin = b;
    x.locked = l; x.step_err = se; x.wraps = w; x.ovf = o;
    return x;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply inputs away from the rising edge, then let one edge pass.
  task automatic apply(logic r, logic v, logic [2:0] g);
    @(negedge Clk);
    Reset  = r;
    Valid  = v;
    GrayIn = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all(string nm, logic [2:0] b, logic l, logic se, logic [3:0] w, logic o);
    chk({nm, ".Binary"},    8'(Binary),    8'(b));
    chk({nm, ".Locked"},    8'(Locked),    8'(l));
    chk({nm, ".StepError"}, 8'(StepError), 8'(se));
    chk({nm, ".Wraps"},     8'(Wraps),     8'(w));
    chk({nm, ".Overflow"},  8'(Overflow),  8'(o));
  endtask

  initial begin
    Reset  = 1'b0;
    Valid  = 1'b0;
    GrayIn = '0;

    // Full sequence, then mid-stream reset clearing wrap state
    vecs.push_back(mk("reset",     0, 0, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("seq0",      1, 1, 3'b000, 0, 1, 0, 0, 0));
    vecs.push_back(mk("seq1",      1, 1, 3'b001, 1, 1, 0, 0, 0));
    vecs.push_back(mk("seq2",      1, 1, 3'b011, 2, 1, 0, 0, 0));
    vecs.push_back(mk("seq3",      1, 1, 3'b010, 3, 1, 0, 0, 0));
    vecs.push_back(mk("seq4",      1, 1, 3'b110, 4, 1, 0, 0, 0));
    vecs.push_back(mk("seq5",      1, 1, 3'b111, 5, 1, 0, 0, 0));
    vecs.push_back(mk("seq6",      1, 1, 3'b101, 6, 1, 0, 0, 0));
    vecs.push_back(mk("seq7",      1, 1, 3'b100, 7, 1, 0, 0, 0));
    vecs.push_back(mk("seq_wrap",  1, 1, 3'b000, 0, 1, 0, 1, 1));
    vecs.push_back(mk("seq_post",  1, 1, 3'b001, 1, 1, 0, 1, 1));
    vecs.push_back(mk("mid_rst",   0, 1, 3'b110, 0, 0, 0, 0, 0));
    vecs.push_back(mk("post_rst",  1, 1, 3'b101, 6, 1, 0, 0, 0));
    vecs.push_back(mk("post_rst2", 1, 1, 3'b100, 7, 1, 0, 0, 0));
    vecs.push_back(mk("hold",      1, 0, 3'b011, 7, 1, 0, 0, 0));
    // Repeat
    vecs.push_back(mk("rep_rst",   0, 0, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rep_lock",  1, 1, 3'b011, 2, 1, 0, 0, 0));
    vecs.push_back(mk("rep_same",  1, 1, 3'b011, 2, 1, 0, 0, 0));
    // Skip then relock
    vecs.push_back(mk("skp_rst",   0, 0, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("skp_lock",  1, 1, 3'b001, 1, 1, 0, 0, 0));
    vecs.push_back(mk("skp_err",   1, 1, 3'b010, 1, 0, 1, 0, 0));
    vecs.push_back(mk("skp_idle",  1, 0, 3'b010, 1, 0, 0, 0, 0));
    vecs.push_back(mk("skp_relk",  1, 1, 3'b110, 4, 1, 0, 0, 0));
    // Backward step; 111 from Binary=2 would error in TRACK, so relock shows FAULT
    vecs.push_back(mk("bwd_rst",   0, 0, 3'b000, 0, 0, 0, 0, 0));
    vecs.push_back(mk("bwd_lock",  1, 1, 3'b011, 2, 1, 0, 0, 0));
    vecs.push_back(mk("bwd_err",   1, 1, 3'b001, 2, 0, 1, 0, 0));
    vecs.push_back(mk("bwd_relk",  1, 1, 3'b111, 5, 1, 0, 0, 0));
    // Reset dominates Valid while in FAULT
    vecs.push_back(mk("flt_err",   1, 1, 3'b000, 5, 0, 1, 0, 0));
    vecs.push_back(mk("flt_rst",   0, 1, 3'b110, 0, 0, 0, 0, 0));
    vecs.push_back(mk("flt_first", 1, 1, 3'b010, 3, 1, 0, 0, 0));
    vecs.push_back(mk("flt_step",  1, 1, 3'b110, 4, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst_n, vecs[i].valid, vecs[i].gray);
      chk_all(vecs[i].name, vecs[i].bin, vecs[i].locked, vecs[i].step_err,
              vecs[i].wraps, vecs[i].ovf);
    end

    // Saturation: 17 full wraps with random idle gaps of 0-3 cycles.
    begin
      logic [2:0] gray_seq [8];
      int         exp_wraps;
      logic [2:0] exp_bin;
      gray_seq[0] = 3'b000; gray_seq[1] = 3'b001; gray_seq[2] = 3'b011; gray_seq[3] = 3'b010;
      gray_seq[4] = 3'b110; gray_seq[5] = 3'b111; gray_seq[6] = 3'b101; gray_seq[7] = 3'b100;
      exp_wraps = 0;
      apply(0, 0, 3'b000);
      apply(1, 1, 3'b000);
      exp_bin = 3'd0;
      chk_all("sat_lock", 0, 1, 0, 0, 0);
      for (int w = 0; w < 17; w++) begin
        for (int k = 1; k <= 8; k++) begin
          int gap;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) begin
            apply(1, 0, gray_seq[(k + 3) % 8]);
            chk_all("sat_gap", exp_bin, 1, 0, 4'(exp_wraps), (exp_wraps > 0));
          end
          apply(1, 1, gray_seq[k % 8]);
          exp_bin = 3'(k % 8);
          if (k == 8 && exp_wraps < 15) exp_wraps++;
          chk_all("sat_step", exp_bin, 1, 0, 4'(exp_wraps), (exp_wraps > 0));
        end
      end
      chk("sat_final.Wraps",    8'(Wraps),    8'd15);
      chk("sat_final.Overflow", 8'(Overflow), 8'd1);
    end

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
